// File: rtl/bus_pkg.sv
// Shared definitions for the bus slave response path: FSM encoding,
// active-low level constants and default block parameters.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int DEF_CH      = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/bus_slave_resp_mux_if.sv
// Slave-channel and master-response signals of the bus response multiplexer.
interface bus_slave_resp_mux_if #(
    parameter int CH     = bus_pkg::DEF_CH,
    parameter int DATA_W = bus_pkg::DEF_DATA_W
);
    localparam int IDX_W = $clog2(CH);

    // Handshake: s_cs_[i] low opens an access on slave i, s_rdy_[i] low with
    // s_rd_data completes it; m_rdy_ low for exactly one cycle presents the
    // response, and m_err/err_ch are only meaningful while m_rdy_ is low.
    logic [CH-1:0]        s_cs_;
    logic [CH*DATA_W-1:0] s_rd_data;
    logic [CH-1:0]        s_rdy_;
    logic [DATA_W-1:0]    m_rd_data;
    logic                 m_rdy_;
    logic                 m_err;
    logic [IDX_W-1:0]     err_ch;

    // Seen from the bus master, the multiplexer is the slave.
    modport slave (
        input  s_cs_, s_rd_data, s_rdy_,
        output m_rd_data, m_rdy_, m_err, err_ch
    );

    modport master (
        output s_cs_, s_rd_data, s_rdy_,
        input  m_rd_data, m_rdy_, m_err, err_ch
    );

endinterface

// File: rtl/bus_slave_prio_enc.sv
// Lowest-index-wins priority encoder over active-low chip selects.
module bus_slave_prio_enc
    import bus_pkg::*;
#(
    parameter int CH = DEF_CH,
    localparam int IDX_W = $clog2(CH)
) (
    input  logic [CH-1:0]    cs_,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    assign any = ~(&cs_);

    // Scanning downwards lets the lowest asserted index overwrite the rest.
    always_comb begin
        idx = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (cs_[i] == ENABLE_) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_slave_resp_mux.sv
// Registered slave response multiplexer with latched selection.
// Define BUS_SLAVE_TIMEOUT_EN to build the wait-state watchdog.
module bus_slave_resp_mux
    import bus_pkg::*;
#(
    parameter int CH      = DEF_CH,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_,
    bus_slave_resp_mux_if.slave bus,
    output state_t              dbg_state
);

    localparam int IDX_W = $clog2(CH);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    enc_idx, cur_idx;
    logic                enc_any, cur_rdy;
    logic [DATA_W-1:0]   cur_data;

`ifdef BUS_SLAVE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    err_ch_q, err_ch_d;
`endif

    bus_slave_prio_enc #(.CH(CH)) u_prio_enc (
        .cs_ (bus.s_cs_),
        .idx (enc_idx),
        .any (enc_any)
    );

    // IDLE looks at the fresh winner; every later cycle uses the latched one.
    assign cur_idx   = (state_q == IDLE) ? enc_idx : sel_q;
    assign cur_data  = bus.s_rd_data[int'(cur_idx)*DATA_W +: DATA_W];
    assign cur_rdy   = (bus.s_rdy_[cur_idx] == ENABLE_);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            data_q   <= '0;
`ifdef BUS_SLAVE_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
            err_ch_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
`ifdef BUS_SLAVE_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            err_ch_q <= err_ch_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        data_d   = data_q;
`ifdef BUS_SLAVE_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
        err_ch_d = err_ch_q;
`endif
        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    sel_d = enc_idx;
                    if (cur_rdy) begin
                        data_d  = cur_data;
                        state_d = RESP;
`ifdef BUS_SLAVE_TIMEOUT_EN
                        err_d    = 1'b0;
                        err_ch_d = '0;
`endif
                    end else begin
                        state_d = WAIT;
`ifdef BUS_SLAVE_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end
                end
            end
            WAIT: begin
                // Abort beats ready; ready beats the watchdog in the same cycle.
                if (bus.s_cs_[sel_q] == DISABLE_) begin
                    state_d = IDLE;
                end else if (cur_rdy) begin
                    data_d  = cur_data;
                    state_d = RESP;
`ifdef BUS_SLAVE_TIMEOUT_EN
                    err_d    = 1'b0;
                    err_ch_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    data_d   = '0;
                    err_d    = 1'b1;
                    err_ch_d = sel_q;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.m_rdy_    = DISABLE_;
        bus.m_rd_data = '0;
        bus.m_err     = 1'b0;
        bus.err_ch    = '0;
        if (state_q == RESP) begin
            bus.m_rdy_    = ENABLE_;
            bus.m_rd_data = data_q;
`ifdef BUS_SLAVE_TIMEOUT_EN
            bus.m_err     = err_q;
            bus.err_ch    = err_ch_q;
`endif
        end
    end

endmodule
